sdram_arb: RTL and testbench

SDRAM_ARB -- requirements
Module: sdram_arb

---
 rtl/sdram_arb_if.sv | 38 +++
 rtl/sdram_arb.sv | 131 +++++++++++++
 tb/tb_sdram_arb.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_arb_if.sv
// Client strobe/data ports and toggle-handshake controller port of sdram_arb.
// master = arbiter side; slave = clients plus the SDRAM controller.
interface sdram_arb_if #(
  parameter int AW = 24
);
  logic          c0_rd, c0_wr, c0_busy;
  logic [AW:1]   c0_addr;
  logic [1:0]    c0_ds;
  logic [15:0]   c0_din, c0_dout;

  logic          c1_rd, c1_wr, c1_busy;
  logic [AW:1]   c1_addr;
  logic [1:0]    c1_ds;
  logic [15:0]   c1_din, c1_dout;

  logic          mem_req, mem_ack, mem_we;
  logic [AW:1]   mem_a;
  logic [1:0]    mem_ds;
  logic [15:0]   mem_d, mem_q;

  modport master (
    input  c0_rd, c0_wr, c0_addr, c0_ds, c0_din,
    output c0_dout, c0_busy,
    input  c1_rd, c1_wr, c1_addr, c1_ds, c1_din,
    output c1_dout, c1_busy,
    output mem_req, mem_we, mem_a, mem_ds, mem_d,
    input  mem_ack, mem_q
  );

  modport slave (
    output c0_rd, c0_wr, c0_addr, c0_ds, c0_din,
    input  c0_dout, c0_busy,
    output c1_rd, c1_wr, c1_addr, c1_ds, c1_din,
    input  c1_dout, c1_busy,
    input  mem_req, mem_we, mem_a, mem_ds, mem_d,
    output mem_ack, mem_q
  );
endinterface

// File: rtl/sdram_arb.sv
// Two-client arbiter onto a toggle req/ack SDRAM port; issue >=1 cycle after accept, one access in flight, strobes while busy dropped.
// Fixed client-0 priority on contention; SDRAM_ARB_RR_EN selects round-robin via a last-grant bit.
module sdram_arb #(
  parameter int AW = 24
) (
  input  logic        clk,
  input  logic        reset,
  sdram_arb_if.master bus
);

  typedef enum logic {IDLE, WAIT} state_t;
  state_t state, state_nx;

  logic [1:0]  pend, slot_we, stb, wr_in;
  logic [AW:1] slot_a  [2];
  logic [1:0]  slot_ds [2];
  logic [15:0] slot_d  [2];
  logic [15:0] dout    [2];
  logic [AW:1] in_a    [2];
  logic [1:0]  in_ds   [2];
  logic [15:0] in_d    [2];

  logic        gnt, pick, issue, done;
  logic        req_q, we_q;
  logic [AW:1] a_q;
  logic [1:0]  ds_q;
  logic [15:0] d_q;
`ifdef SDRAM_ARB_RR_EN
  logic        last;
`endif

  // Read+write together counts as a write: direction comes from wr alone.
  assign stb      = {bus.c1_rd | bus.c1_wr, bus.c0_rd | bus.c0_wr};
  assign wr_in    = {bus.c1_wr, bus.c0_wr};
  assign in_a[0]  = bus.c0_addr;
  assign in_a[1]  = bus.c1_addr;
  assign in_ds[0] = bus.c0_ds;
  assign in_ds[1] = bus.c1_ds;
  assign in_d[0]  = bus.c0_din;
  assign in_d[1]  = bus.c1_din;

  always_comb begin
`ifdef SDRAM_ARB_RR_EN
    pick = (pend == 2'b11) ? ~last : pend[1];
`else
    pick = ~pend[0];
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: if (pend != 2'b00) begin
        issue    = 1'b1;
        state_nx = WAIT;
      end
      WAIT: if (bus.mem_ack == req_q) begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // Track ack so a toggle arriving during reset never looks like a request.
      req_q   <= bus.mem_ack;
      we_q    <= 1'b0;
      a_q     <= '0;
      ds_q    <= 2'b00;
      d_q     <= '0;
      gnt     <= 1'b0;
      pend    <= 2'b00;
      slot_we <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        slot_a[i]  <= '0;
        slot_ds[i] <= 2'b00;
        slot_d[i]  <= '0;
        dout[i]    <= '0;
      end
`ifdef SDRAM_ARB_RR_EN
      last    <= 1'b1;
`endif
    end else begin
      if (issue) begin
        gnt   <= pick;
        req_q <= ~req_q;
        we_q  <= slot_we[pick];
        a_q   <= slot_a[pick];
        ds_q  <= slot_ds[pick];
        d_q   <= slot_d[pick];
`ifdef SDRAM_ARB_RR_EN
        last  <= pick;
`endif
      end
      if (done) begin
        pend[gnt] <= 1'b0;
        if (!we_q) dout[gnt] <= bus.mem_q;
      end
      // A slot still pending (including the one completing now) ignores strobes.
      for (int i = 0; i < 2; i++) begin
        if (stb[i] && !pend[i]) begin
          pend[i]    <= 1'b1;
          slot_we[i] <= wr_in[i];
          slot_a[i]  <= in_a[i];
          slot_ds[i] <= in_ds[i];
          slot_d[i]  <= in_d[i];
        end
      end
    end
  end

  assign bus.c0_busy = pend[0];
  assign bus.c1_busy = pend[1];
  assign bus.c0_dout = dout[0];
  assign bus.c1_dout = dout[1];
  assign bus.mem_req = req_q;
  assign bus.mem_we  = we_q;
  assign bus.mem_a   = a_q;
  assign bus.mem_ds  = ds_q;
  assign bus.mem_d   = d_q;

endmodule

// File: tb/tb_sdram_arb.sv
// Bench for sdram_arb: transaction-level model plus controller responder, all driven from one process.
module tb_sdram_arb;
  localparam int AW = 24;
`ifdef SDRAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct packed {
    logic        we;
    logic [AW:1] a;
    logic [1:0]  ds;
    logic [15:0] d;
  } req_t;

  logic clk, reset;
  sdram_arb_if #(.AW(AW)) bus ();
  sdram_arb #(.AW(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0, n_pass = 0;

  // Reference model state
  req_t        m_slot [2];
  logic [1:0]  m_pend;
  logic        m_out, m_last, m_req;
  int          m_gnt;
  req_t        m_cur;
  logic [15:0] m_dout [2];

  // Controller responder
  bit          ctl_busy;
  int          ctl_cnt;
  bit          ctl_we;
  int          fix_delay = -1;
  bit          fix_data_en;
  logic [15:0] fix_data;

  // Issue monitor
  logic        mon_req;
  req_t        issued [$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_step();
    logic [1:0] was, stb;
    req_t r [2];
    was  = m_pend;
    stb  = {bus.c1_rd | bus.c1_wr, bus.c0_rd | bus.c0_wr};
    r[0] = {bus.c0_wr, bus.c0_addr, bus.c0_ds, bus.c0_din};
    r[1] = {bus.c1_wr, bus.c1_addr, bus.c1_ds, bus.c1_din};
    if (reset) begin
      m_req = bus.mem_ack;
      m_pend = 2'b00;
      m_out = 1'b0;
      m_last = 1'b1;
      m_dout[0] = '0;
      m_dout[1] = '0;
      m_cur = '0;
      m_gnt = 0;
    end else begin
      if (m_out) begin
        if (bus.mem_ack == m_req) begin
          m_pend[m_gnt] = 1'b0;
          if (!m_cur.we) m_dout[m_gnt] = bus.mem_q;
          m_out = 1'b0;
        end
      end else if (m_pend != 2'b00) begin
        if (m_pend == 2'b11) m_gnt = (RR && !m_last) ? 1 : 0;
        else                 m_gnt = m_pend[1] ? 1 : 0;
        m_last = (m_gnt == 1);
        m_cur  = m_slot[m_gnt];
        m_req  = ~m_req;
        m_out  = 1'b1;
      end
      for (int n = 0; n < 2; n++)
        if (!was[n] && stb[n]) begin
          m_pend[n] = 1'b1;
          m_slot[n] = r[n];
        end
    end
  endtask

  task automatic compare();
    chk("c0_busy", 32'(bus.c0_busy), 32'(m_pend[0]));
    chk("c1_busy", 32'(bus.c1_busy), 32'(m_pend[1]));
    chk("c0_dout", 32'(bus.c0_dout), 32'(m_dout[0]));
    chk("c1_dout", 32'(bus.c1_dout), 32'(m_dout[1]));
    chk("mem_req", 32'(bus.mem_req), 32'(m_req));
    if (m_out) begin
      chk("mem_we", 32'(bus.mem_we), 32'(m_cur.we));
      chk("mem_a",  32'(bus.mem_a),  32'(m_cur.a));
      chk("mem_ds", 32'(bus.mem_ds), 32'(m_cur.ds));
      chk("mem_d",  32'(bus.mem_d),  32'(m_cur.d));
    end
  endtask

  task automatic monitor();
    if (!reset && bus.mem_req !== mon_req)
      issued.push_back({bus.mem_we, bus.mem_a, bus.mem_ds, bus.mem_d});
    mon_req = bus.mem_req;
  endtask

  task automatic controller();
    if (!ctl_busy && !reset && bus.mem_req !== bus.mem_ack) begin
      ctl_busy = 1'b1;
      ctl_cnt  = (fix_delay >= 0) ? fix_delay : $urandom_range(0, 6);
      ctl_we   = bus.mem_we;
    end
    if (ctl_busy) begin
      if (ctl_cnt == 0) begin
        if (!ctl_we) bus.mem_q = fix_data_en ? fix_data : 16'($urandom);
        bus.mem_ack = ~bus.mem_ack;
        ctl_busy = 1'b0;
      end else ctl_cnt--;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
    monitor();
    controller();
  endtask

  task automatic set_client(int n, bit rd, bit wr, logic [AW:1] a, logic [1:0] ds, logic [15:0] d);
    if (n == 0) begin
      bus.c0_rd = rd; bus.c0_wr = wr; bus.c0_addr = a; bus.c0_ds = ds; bus.c0_din = d;
    end else begin
      bus.c1_rd = rd; bus.c1_wr = wr; bus.c1_addr = a; bus.c1_ds = ds; bus.c1_din = d;
    end
  endtask

  task automatic clear_strobes();
    bus.c0_rd = 1'b0; bus.c0_wr = 1'b0;
    bus.c1_rd = 1'b0; bus.c1_wr = 1'b0;
  endtask

  task automatic wait_idle(string name);
    int k = 0;
    while ((bus.c0_busy || bus.c1_busy) && k < 300) begin
      tick();
      k++;
    end
    chk(name, 32'(bus.c0_busy | bus.c1_busy), 32'd0);
  endtask

  function automatic req_t issued_at(int i);
    if (i < issued.size()) return issued[i];
    return '0;
  endfunction

  initial begin
    int base, c0n, c1n;
    logic [AW:1] exp4 [4];
    logic [AW:1] exp2 [2];

    reset = 1'b1;
    clear_strobes();
    set_client(0, 0, 0, '0, 2'b00, '0);
    set_client(1, 0, 0, '0, 2'b00, '0);
    bus.mem_ack = 1'b0;
    bus.mem_q   = '0;
    fix_data_en = 1'b0;
    fix_data    = '0;
    mon_req     = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mem_we",  32'(bus.mem_we),  32'd0);
    chk("rst_mem_a",   32'(bus.mem_a),   32'd0);
    chk("rst_mem_ds",  32'(bus.mem_ds),  32'd0);
    chk("rst_mem_d",   32'(bus.mem_d),   32'd0);
    chk("rst_c0_dout", 32'(bus.c0_dout), 32'd0);

    // Client 0 read, controller answers 0xBEEF after 8 cycles
    fix_delay = 8; fix_data_en = 1'b1; fix_data = 16'hBEEF;
    base = issued.size();
    set_client(0, 1, 0, 24'h000123, 2'b11, 16'h0);
    tick(); clear_strobes();
    chk("rd_busy_rise", 32'(bus.c0_busy), 32'd1);
    wait_idle("rd_timeout");
    chk("rd_dout",   32'(bus.c0_dout), 32'hBEEF);
    chk("rd_count",  32'(issued.size() - base), 32'd1);
    chk("rd_mem_a",  32'(issued_at(base).a), 32'h000123);
    chk("rd_mem_we", 32'(issued_at(base).we), 32'd0);

    // Client 1 write; its read data must stay untouched
    fix_delay = 4;
    base = issued.size();
    set_client(1, 0, 1, 24'h7FFFFF, 2'b01, 16'h5A5A);
    tick(); clear_strobes();
    wait_idle("wr_timeout");
    chk("wr_count",  32'(issued.size() - base), 32'd1);
    chk("wr_mem_we", 32'(issued_at(base).we), 32'd1);
    chk("wr_mem_a",  32'(issued_at(base).a), 32'h7FFFFF);
    chk("wr_mem_ds", 32'(issued_at(base).ds), 32'd1);
    chk("wr_mem_d",  32'(issued_at(base).d), 32'h5A5A);
    chk("wr_c1_dout", 32'(bus.c1_dout), 32'd0);

    // Strobe while busy is dropped
    fix_delay = 6; fix_data = 16'h1234;
    base = issued.size();
    set_client(0, 1, 0, 24'h000123, 2'b11, 16'h0);
    tick(); clear_strobes();
    set_client(0, 1, 0, 24'h000456, 2'b11, 16'h0);
    tick(); clear_strobes();
    tick();
    set_client(0, 0, 1, 24'h000456, 2'b10, 16'h7777);
    tick(); clear_strobes();
    wait_idle("busy_timeout");
    repeat (4) tick();
    chk("busy_count", 32'(issued.size() - base), 32'd1);
    chk("busy_mem_a", 32'(issued_at(base).a), 32'h000123);
    chk("busy_dout",  32'(bus.c0_dout), 32'h1234);

    // Both clients read together, each re-strobes as soon as its busy drops
    fix_delay = 3; fix_data_en = 1'b0;
    base = issued.size();
    set_client(0, 1, 0, 24'h000010, 2'b11, 16'h0);
    set_client(1, 1, 0, 24'h000020, 2'b11, 16'h0);
    tick(); clear_strobes();
    c0n = 1; c1n = 1;
    for (int k = 0; k < 200 && !(issued.size() == base + 4 && !bus.c0_busy && !bus.c1_busy); k++) begin
      if (!bus.c0_busy && c0n < 2) begin set_client(0, 1, 0, 24'h000011, 2'b11, 16'h0); c0n++; end
      if (!bus.c1_busy && c1n < 2) begin set_client(1, 1, 0, 24'h000021, 2'b11, 16'h0); c1n++; end
      tick(); clear_strobes();
    end
    exp4[0] = 24'h000010; exp4[1] = 24'h000020; exp4[2] = 24'h000011; exp4[3] = 24'h000021;
    chk("pair_count", 32'(issued.size() - base), 32'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("pair_order%0d", i), 32'(issued_at(base + i).a), 32'(exp4[i]));

    // Contention right after a client-0 grant separates fixed priority from round-robin
    base = issued.size();
    set_client(0, 1, 0, 24'h000030, 2'b11, 16'h0);
    tick(); clear_strobes();
    wait_idle("arb_timeout0");
    set_client(0, 1, 0, 24'h000031, 2'b11, 16'h0);
    set_client(1, 1, 0, 24'h000040, 2'b11, 16'h0);
    tick(); clear_strobes();
    wait_idle("arb_timeout1");
    if (RR) begin exp2[0] = 24'h000040; exp2[1] = 24'h000031; end
    else    begin exp2[0] = 24'h000031; exp2[1] = 24'h000040; end
    chk("arb_count",  32'(issued.size() - base), 32'd3);
    chk("arb_first",  32'(issued_at(base + 1).a), 32'(exp2[0]));
    chk("arb_second", 32'(issued_at(base + 2).a), 32'(exp2[1]));

    // Reset in WAIT, ack toggles while reset is held
    fix_delay = 5;
    base = issued.size();
    set_client(0, 1, 0, 24'h000050, 2'b11, 16'h0);
    tick(); clear_strobes();
    tick(); tick();
    chk("rstw_issued", 32'(issued.size() - base), 32'd1);
    reset = 1'b1;
    repeat (10) tick();
    reset = 1'b0;
    tick();
    chk("rstw_busy", 32'(bus.c0_busy), 32'd0);
    chk("rstw_req_eq_ack", 32'(bus.mem_req), 32'(bus.mem_ack));
    repeat (20) tick();
    chk("rstw_no_reissue", 32'(issued.size() - base), 32'd1);
    chk("rstw_busy_late", 32'(bus.c0_busy), 32'd0);

    // Reset released with ack high
    reset = 1'b1;
    bus.mem_ack = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    base = issued.size();
    tick();
    chk("ack1_req", 32'(bus.mem_req), 32'd1);
    repeat (10) tick();
    chk("ack1_req_hold", 32'(bus.mem_req), 32'd1);
    chk("ack1_no_issue", 32'(issued.size() - base), 32'd0);

    // Random traffic against the model
    fix_delay = -1;
    repeat (3000) begin
      for (int n = 0; n < 2; n++)
        if ($urandom_range(0, 2) == 0)
          set_client(n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     AW'($urandom), 2'($urandom), 16'($urandom));
      tick(); clear_strobes();
    end
    wait_idle("rand_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
